bus_master_port: RTL

//  Master-side requester for the shared backplane bus; the stage directly upstream of the bus arbiter.

---
 rtl/bus_master_port.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/bus_master_port.sv
`default_nettype none
// ============================================================================
// Module   : bus_master_port
// Purpose  : Master-side requester turning one local read/write request into
//            the backplane barq/bagd/target_ready/address_valid/data_strobe
//            handshake, with arbiter-error and local-watchdog abort.
// Revision : 1.0  initial release
// ============================================================================
module bus_master_port #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int LOCAL_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    // local request side
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic              rsp_error_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    // backplane side
    output logic              barq_o,
    input  logic              bagd_i,
    input  logic              target_ready_i,
    output logic              address_valid_o,
    input  logic              data_strobe_i,
    input  logic              bus_error_i,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic              bus_wr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i
);

    localparam int              WD_W       = $clog2(LOCAL_TIMEOUT + 1);
    localparam logic [WD_W-1:0] c_WD_LIMIT = WD_W'(LOCAL_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_ADDR    = 3'd2,
        S_STROBE  = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WD_W-1:0]   r_wd;
    logic [WD_W-1:0]   w_wd_nxt;

    logic              r_lat_wr;
    logic [ADDR_W-1:0] r_lat_addr;
    logic [DATA_W-1:0] r_lat_wdata;
    logic              w_lat_wr_nxt;
    logic [ADDR_W-1:0] w_lat_addr_nxt;
    logic [DATA_W-1:0] w_lat_wdata_nxt;

    logic              r_req_ready;
    logic              r_rsp_valid;
    logic              r_rsp_error;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_barq;
    logic              r_addr_valid;
    logic [ADDR_W-1:0] r_bus_addr;
    logic              r_bus_wr;
    logic [DATA_W-1:0] r_bus_wdata;

    logic              w_req_ready_nxt;
    logic              w_rsp_valid_nxt;
    logic              w_rsp_error_nxt;
    logic [DATA_W-1:0] w_rsp_rdata_nxt;
    logic              w_barq_nxt;
    logic              w_addr_valid_nxt;
    logic [ADDR_W-1:0] w_bus_addr_nxt;
    logic              w_bus_wr_nxt;
    logic [DATA_W-1:0] w_bus_wdata_nxt;

    logic              w_in_bus;
    logic              w_abort;
    logic              w_bus_active;

    // Every output is a register loaded from the value it must show once the
    // next state is entered, so outputs change on the same edge as the state.
    always_comb begin
        w_state_nxt     = r_state;
        w_wd_nxt        = r_wd;
        w_lat_wr_nxt    = r_lat_wr;
        w_lat_addr_nxt  = r_lat_addr;
        w_lat_wdata_nxt = r_lat_wdata;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_error_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;

        w_in_bus = (r_state == S_REQ) || (r_state == S_ADDR) || (r_state == S_STROBE);
        w_abort  = w_in_bus && (bus_error_i || (r_wd == c_WD_LIMIT));

        if (w_in_bus && (r_wd != c_WD_LIMIT)) begin
            w_wd_nxt = r_wd + WD_W'(1);
        end

        case (r_state)
            S_IDLE: begin
                if (req_valid_i) begin
                    w_lat_wr_nxt    = req_write_i;
                    w_lat_addr_nxt  = req_addr_i;
                    w_lat_wdata_nxt = req_wdata_i;
                    w_wd_nxt        = '0;
                    w_state_nxt     = S_REQ;
                end
            end
            S_REQ: begin
                // an error alongside the grant still aborts
                if (w_abort) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_error_nxt = 1'b1;
                    w_state_nxt     = S_RELEASE;
                end else if (bagd_i) begin
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (w_abort) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_error_nxt = 1'b1;
                    w_state_nxt     = S_RELEASE;
                end else if (target_ready_i) begin
                    w_state_nxt = S_STROBE;
                end
            end
            S_STROBE: begin
                // a completed data phase takes precedence over any abort cause
                if (data_strobe_i) begin
                    w_rsp_valid_nxt = 1'b1;
                    if (!r_lat_wr) begin
                        w_rsp_rdata_nxt = bus_rdata_i;
                    end
                    w_state_nxt = S_RELEASE;
                end else if (w_abort) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_error_nxt = 1'b1;
                    w_state_nxt     = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!bagd_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_bus_active     = (w_state_nxt == S_ADDR) || (w_state_nxt == S_STROBE);
        w_req_ready_nxt  = (w_state_nxt == S_IDLE);
        w_barq_nxt       = (w_state_nxt == S_REQ) || w_bus_active;
        w_addr_valid_nxt = (w_state_nxt == S_STROBE);
        w_bus_addr_nxt   = w_bus_active ? w_lat_addr_nxt : '0;
        w_bus_wr_nxt     = w_bus_active && w_lat_wr_nxt;
        w_bus_wdata_nxt  = (w_bus_active && w_lat_wr_nxt) ? w_lat_wdata_nxt : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wd         <= '0;
            r_lat_wr     <= 1'b0;
            r_lat_addr   <= '0;
            r_lat_wdata  <= '0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_error  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_barq       <= 1'b0;
            r_addr_valid <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_wr     <= 1'b0;
            r_bus_wdata  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_wd         <= w_wd_nxt;
            r_lat_wr     <= w_lat_wr_nxt;
            r_lat_addr   <= w_lat_addr_nxt;
            r_lat_wdata  <= w_lat_wdata_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_error  <= w_rsp_error_nxt;
            r_rsp_rdata  <= w_rsp_rdata_nxt;
            r_barq       <= w_barq_nxt;
            r_addr_valid <= w_addr_valid_nxt;
            r_bus_addr   <= w_bus_addr_nxt;
            r_bus_wr     <= w_bus_wr_nxt;
            r_bus_wdata  <= w_bus_wdata_nxt;
        end
    end

    assign req_ready_o     = r_req_ready;
    assign rsp_valid_o     = r_rsp_valid;
    assign rsp_error_o     = r_rsp_error;
    assign rsp_rdata_o     = r_rsp_rdata;
    assign barq_o          = r_barq;
    assign address_valid_o = r_addr_valid;
    assign bus_addr_o      = r_bus_addr;
    assign bus_wr_o        = r_bus_wr;
    assign bus_wdata_o     = r_bus_wdata;

endmodule
`default_nettype wire
